// File: rtl/counter_monitor_pkg.sv
// Shared definitions for the counter monitor: the checker FSM state encoding
// and its width. The encoding is visible on state_o for debug.
package counter_monitor_pkg;

    localparam int STATE_W = 2;

    // Checker states; the numeric values are exposed on state_o.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage : counter_monitor_pkg

// File: rtl/cnt_ref_model.sv
// Reference model of the observed counter. It holds the expected count and
// advances it independently of the observed value once loaded, so a stuck or
// skipping counter keeps producing mismatches rather than being re-synced.
module cnt_ref_model #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] exp,
    output logic             wrap_nxt
);

    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_d;

    // Next expected count: a load (re-sync) wins over an increment.
    always_comb begin
        exp_d = exp_q;
        if (load) begin
            exp_d = load_val;
        end else if (inc) begin
            exp_d = exp_q + WIDTH'(1);
        end
    end

    // Expected-count register, cleared together with the observed counter.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            exp_q <= '0;
        end else begin
            exp_q <= exp_d;
        end
    end

    assign exp = exp_q;

    // The expected count rolls over from all-ones to zero at the next edge.
    assign wrap_nxt = inc && !load && (&exp_q);

endmodule : cnt_ref_model

// File: rtl/counter_monitor.sv
// Passive checker for a modulo-2^WIDTH enable counter. It re-syncs its
// reference model to the observed count for one cycle, then predicts every
// following value and flags, counts and captures any disagreement.
module counter_monitor
    import counter_monitor_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int ERR_CNT_W   = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 chk_en,
    input  logic                 clr_err,
    input  logic                 in,
    input  logic [WIDTH-1:0]     q,
    output logic                 err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 first_vld,
    output logic [WIDTH-1:0]     first_exp,
    output logic [WIDTH-1:0]     first_obs,
    output logic                 wrap,
    output logic [STATE_W-1:0]   state_o
);

    state_e                 state_q;
    logic                   err_q;
    logic                   wrap_q;

    logic                   sticky_q;
    logic                   sticky_d;
    logic [ERR_CNT_W-1:0]   cnt_q;
    logic [ERR_CNT_W-1:0]   cnt_d;
    logic                   fvld_q;
    logic                   fvld_d;
    logic [WIDTH-1:0]       fexp_q;
    logic [WIDTH-1:0]       fexp_d;
    logic [WIDTH-1:0]       fobs_q;
    logic [WIDTH-1:0]       fobs_d;

    logic [WIDTH-1:0]       exp_w;
    logic                   wrap_nxt_w;
    logic                   load_w;
    logic [WIDTH-1:0]       load_val_w;
    logic                   inc_w;
    logic                   mismatch_w;

    // The SYNC cycle adopts the value the counter will hold after this edge.
    assign load_w     = (state_q == ST_SYNC);
    assign load_val_w = q + {{(WIDTH-1){1'b0}}, in};

    // The model only advances while actively checking; IDLE and HALT freeze it.
    assign inc_w      = (state_q == ST_CHECK) && in;

    cnt_ref_model #(
        .WIDTH    (WIDTH)
    ) u_ref (
        .clk      (clk),
        .rstb     (rstb),
        .load     (load_w),
        .load_val (load_val_w),
        .inc      (inc_w),
        .exp      (exp_w),
        .wrap_nxt (wrap_nxt_w)
    );

    // Comparisons happen only in CHECK; the result is registered into err.
    assign mismatch_w = (state_q == ST_CHECK) && (q != exp_w);

    // Checker FSM plus its registered one-cycle pulses.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            err_q  <= mismatch_w;
            wrap_q <= wrap_nxt_w;
            case (state_q)
                ST_IDLE: begin
                    if (chk_en) begin
                        state_q <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    state_q <= chk_en ? ST_CHECK : ST_IDLE;
                end
                ST_CHECK: begin
                    if (!chk_en) begin
                        state_q <= ST_IDLE;
                    end else if (STOP_ON_ERR && mismatch_w) begin
                        state_q <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    // Disabling the checker outranks a restart request.
                    if (!chk_en) begin
                        state_q <= ST_IDLE;
                    end else if (clr_err) begin
                        state_q <= ST_SYNC;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Error status next state: a clear is applied first, then a coincident
    // mismatch is recorded on top of the cleared values.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        fvld_d   = fvld_q;
        fexp_d   = fexp_q;
        fobs_d   = fobs_q;
        if (clr_err) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
            fvld_d   = 1'b0;
            fexp_d   = '0;
            fobs_d   = '0;
        end
        if (mismatch_w) begin
            sticky_d = 1'b1;
            if (cnt_d != {ERR_CNT_W{1'b1}}) begin
                cnt_d = cnt_d + ERR_CNT_W'(1);
            end
            if (!fvld_d) begin
                fvld_d = 1'b1;
                fexp_d = exp_w;
                fobs_d = q;
            end
        end
    end

    // Error status registers; held in every state until cleared or reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            fvld_q   <= 1'b0;
            fexp_q   <= '0;
            fobs_q   <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            fvld_q   <= fvld_d;
            fexp_q   <= fexp_d;
            fobs_q   <= fobs_d;
        end
    end

    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;
    assign first_vld  = fvld_q;
    assign first_exp  = fexp_q;
    assign first_obs  = fobs_q;
    assign wrap       = wrap_q;
    assign state_o    = state_q;

endmodule : counter_monitor

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
- Passive checker sitting on the output side of a `counter` instance.
- Observes the same clock, reset, enable `in` and count output `Q`, and predicts the expected count with an internal reference model.
- Flags, counts and captures mismatches.
- Used in counter benches and as an optional synthesizable on-chip self-check next to `counter`.

Parameters:
- WIDTH, 4: width of the observed counter output `Q`.
- ERR_CNT_W, 8: width of the saturating mismatch counter.
- STOP_ON_ERR, 0: 1 = stop checking after the first mismatch (HALT) until `clr_err`.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstb  input  1  asynchronous active-low reset; shared with the observed counter.
- chk_en  input  1  checking enable; 0 forces IDLE.
- clr_err  input  1  synchronous clear of error status; one-cycle pulse.
- in  input  1  observed counter enable.
- q  input  WIDTH  observed counter output `Q`.
- err  output  1  registered one-cycle mismatch pulse.
- err_sticky  output  1  set on any mismatch, held until `clr_err` or reset.
- err_cnt  output  ERR_CNT_W  number of mismatches, saturating at all-ones.
- first_vld  output  1  first-mismatch capture is valid.
- first_exp  output  WIDTH  expected value at the first mismatch.
- first_obs  output  WIDTH  observed value at the first mismatch.
- wrap  output  1  one-cycle pulse when the expected count wraps from all-ones to 0.
- state_o  output  2  current FSM state, for debug.

Behaviour:
- Counter protocol being checked:
  - Reset clears `Q` to 0.
  - Each rising edge with `in`=1 gives `Q` <= `Q`+1, modulo 2^WIDTH.
  - `in`=0 holds `Q`.
- Reset (`rstb`=0, asynchronous): `exp`=0, state=IDLE, and every output is 0.
- States: IDLE=0, SYNC=1, CHECK=2, HALT=3.
- IDLE:
  - No comparisons; `exp` is held.
  - Goes to SYNC when `chk_en`=1.
- SYNC (exactly one cycle):
  - `exp` <= `q` + `in`, modulo 2^WIDTH; no comparison is made.
  - Goes to CHECK, or to IDLE if `chk_en`=0.
- CHECK, every cycle:
  - Compare combinationally: mismatch = (`q` != `exp`).
  - Update `exp` <= `exp` + `in`, independent of `q`. There is no auto-resync, so a stuck `q` errors every cycle.
  - On mismatch, at the sampling edge: `err`=1 for the next cycle; `err_cnt` += 1 (saturating); `err_sticky`=1.
  - If `first_vld`=0 on a mismatch: `first_exp`/`first_obs` <= `exp`/`q` and `first_vld`=1.
  - `wrap`=1 for one cycle after an edge where `in`=1 and `exp`=all-ones.
  - `chk_en`=0 goes to IDLE.
  - A mismatch with STOP_ON_ERR=1 goes to HALT.
- HALT:
  - No comparisons; `err` stays 0 and `exp` is frozen.
  - `clr_err` goes to SYNC; `chk_en`=0 goes to IDLE, with `chk_en` taking priority.
- Latency: mismatch in cycle k gives `err` high in cycle k+1. `err_cnt` and `first_*` are also updated at that edge.
- `clr_err`:
  - Clears `err_sticky`, `err_cnt`, `first_vld`, `first_exp` and `first_obs`.
  - Coincident with a mismatch in CHECK: clear, then record that mismatch. Result: `err_cnt`=1, `err_sticky`=1, `first_*` captured from this mismatch, `err` pulses.
- `chk_en` falling while `err` is pending: the pulse still issues; status is held in IDLE.
- Reset mid-CHECK: immediate clear, with no `err` pulse.

Decomposition:
- Package `counter_monitor_pkg`: state encodings (ST_IDLE, ST_SYNC, ST_CHECK, ST_HALT) and the state width constant.
- Sub-module `cnt_ref_model`:
  - Parameter WIDTH; inputs `clk`, `rstb`, `load`, `load_val`, `inc`.
  - Outputs `exp` and `wrap_nxt`.
  - Instantiated once, which keeps the prediction separate from the FSM and status logic.

Test Plan:
- Correct counter, WIDTH=4, `chk_en`=1, `in`=1 for 20 cycles after reset → `err` never asserts, `err_cnt`=0; `wrap` pulses once, after expected 15→0.
- `in` toggling 1,0,0,1,1 with `q` correctly holding at 7 during `in`=0 → no `err`; `exp` tracks 7→7→7→8→9.
- Force `q`=5 for one cycle while `exp`=6 → `err` pulses one cycle later; `err_cnt`=1, `err_sticky`=1, `first_exp`=6, `first_obs`=5, `first_vld`=1. A later mismatch of `q`=2 vs `exp`=9 leaves `first_*` unchanged and gives `err_cnt`=2.
- ERR_CNT_W=2, `q` stuck at 3 with `in`=1 for 6 checked cycles → `err_cnt` saturates at 3 and `err_sticky`=1. Then `clr_err` coincident with a mismatch → `err_cnt`=1.
- STOP_ON_ERR=1, mismatch at `exp`=4 → `state_o`=HALT, `err` only once. Then `clr_err` → one SYNC cycle, then CHECK resumes from `q`.
- `rstb` pulsed low mid-CHECK with `err_cnt`=2 → all outputs 0 asynchronously and `state_o`=IDLE; the SYNC→CHECK sequence restarts after release.
